// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared definitions for the register-file write-back sequencer.
//   RF_ADDR_W / RF_DATA_W : default register index / result widths
//   wb_entry_t            : queued write {rd, data} at the default widths
//   wb_state_t            : write sequencer states
package rf_wb_pkg;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } wb_state_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: synchronous FIFO of pending register writes {rd, data}.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   push, push_rd/data    : enqueue request (ignored when full)
//   pop                   : dequeue request (ignored when empty)
//   full, empty           : derived from the registered count
//   head_ptr, count       : read pointer and occupancy
//   ent_rd, ent_data      : raw storage, indexed by physical slot
//   ent_valid             : per-slot occupancy mask
import rf_wb_pkg::*;

module rf_wb_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [ADDR_W-1:0]              push_rd,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [PTR_W-1:0]               head_ptr,
    output logic [CNT_W-1:0]               count,
    output logic [DEPTH-1:0][ADDR_W-1:0]   ent_rd,
    output logic [DEPTH-1:0][DATA_W-1:0]   ent_data,
    output logic [DEPTH-1:0]               ent_valid
);

    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             cnt;
    logic [DEPTH-1:0][ADDR_W-1:0] rd_mem;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem;
    logic                         push_ok;
    logic                         pop_ok;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_ptr = rd_ptr;
    assign count    = cnt;
    assign ent_rd   = rd_mem;
    assign ent_data = data_mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: every consumer qualifies slots with ent_valid/count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // A slot is occupied when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] offs;
        ent_valid = '0;
        offs      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs         = PTR_W'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, offs} < cnt);
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: write-port sequencer for the 32x32 register file.
// Accepts ALU and load results (load has priority), queues them, and
// replays each as a SETUP / STROBE / RELEASE sequence on rd, write_data
// and write_enabled so the register file sees a clean rising strobe.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   alu_valid/rd/data, alu_ready     : ALU result handshake
//   mem_valid/rd/data, mem_ready     : load result handshake
//   rd, write_data, write_enabled    : registered register-file write port
//   busy                             : queue non-empty or sequence in flight
//   lookup_reg, lookup_hit/data      : bypass query of pending writes
// Build option: define RF_WB_BYPASS_EN to build the bypass compare logic;
// otherwise lookup_hit and lookup_data are tied to zero.
import rf_wb_pkg::*;

module rf_writeback #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enabled,
    output logic              busy,
    input  logic [ADDR_W-1:0] lookup_reg,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_state_t                    state;
    logic                         full;
    logic                         empty;
    logic [PTR_W-1:0]             head_ptr;
    logic [PTR_W-1:0]             next_ptr;
    logic [CNT_W-1:0]             count;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0]             ent_valid;

    logic              mem_fire;
    logic              alu_fire;
    logic              push;
    logic [ADDR_W-1:0] push_rd;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              more_after_pop;
    logic [ADDR_W-1:0] next_rd;
    logic [DATA_W-1:0] next_data;

    // Arbitration: load wins; ALU is only offered ready when no load is pending.
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;

    // Writes to $0 complete the handshake but never reach the queue.
    always_comb begin
        push      = 1'b0;
        push_rd   = alu_rd;
        push_data = alu_data;
        if (mem_fire) begin
            push      = (mem_rd != '0);
            push_rd   = mem_rd;
            push_data = mem_data;
        end else if (alu_fire) begin
            push = (alu_rd != '0);
        end
    end

    assign pop = (state == RELEASE);

    rf_wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_rd   (push_rd),
        .push_data (push_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head_ptr  (head_ptr),
        .count     (count),
        .ent_rd    (ent_rd),
        .ent_data  (ent_data),
        .ent_valid (ent_valid)
    );

    // The outputs are registered, so leaving RELEASE must already load the
    // entry that becomes head after the pop: the second queued entry, or the
    // one being pushed this very cycle when only the current head is queued.
    assign next_ptr       = head_ptr + 1'b1;
    assign more_after_pop = (count > CNT_W'(1)) || push;

    always_comb begin
        if (count > CNT_W'(1)) begin
            next_rd   = ent_rd[next_ptr];
            next_data = ent_data[next_ptr];
        end else begin
            next_rd   = push_rd;
            next_data = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rd            <= '0;
            write_data    <= '0;
            write_enabled <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    write_enabled <= 1'b0;
                    if (!empty) begin
                        rd         <= ent_rd[head_ptr];
                        write_data <= ent_data[head_ptr];
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    write_enabled <= 1'b1;
                    state         <= STROBE;
                end
                STROBE: begin
                    write_enabled <= 1'b0;
                    state         <= RELEASE;
                end
                RELEASE: begin
                    write_enabled <= 1'b0;
                    if (more_after_pop) begin
                        rd         <= next_rd;
                        write_data <= next_data;
                        state      <= SETUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    write_enabled <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE) || !empty;

`ifdef RF_WB_BYPASS_EN
    // Walk from oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PTR_W'(k);
            if (ent_valid[idx] && (ent_rd[idx] == lookup_reg) && (lookup_reg != '0)) begin
                lookup_hit  = 1'b1;
                lookup_data = ent_data[idx];
            end
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{lookup_reg, ent_valid};
    assign lookup_hit    = 1'b0;
    assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed, table-driven bench for rf_writeback.
// A per-cycle vector table covers single write, simultaneous sources and
// the $0 drop; hand-written sequences cover back-pressure, reset during a
// strobe and the bypass lookup. A register-file model latches on the
// rising edge of write_enabled.
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        write_enabled;
    logic        busy;
    logic [4:0]  lookup_reg;
    logic        lookup_hit;
    logic [31:0] lookup_data;

    always #5 clk = ~clk;

    rf_writeback #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .mem_valid     (mem_valid),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .rd            (rd),
        .write_data    (write_data),
        .write_enabled (write_enabled),
        .busy          (busy),
        .lookup_reg    (lookup_reg),
        .lookup_hit    (lookup_hit),
        .lookup_data   (lookup_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model and strobe log.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } strobe_t;

    logic [31:0] regfile [32];
    strobe_t     slog [$];

    always @(posedge write_enabled) begin
        regfile[rd] = write_data;
        slog.push_back('{rd, write_data, cyc});
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_busy;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    int          t;
    int          k;
    int          s0;
    int          acc_cyc [6];
    int          exp_acc [6];
    logic        exp_hit;
    logic [31:0] exp_a;
    logic [31:0] exp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    initial begin
        //          av  ard   adat           mv  mrd   mdat      ar  mr  we  rd    wd             busy
        vec[0]  = '{1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0,    1,  1,  0,  5'd0, 32'h0,         0};
        vec[1]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd0, 32'h0,         1};
        vec[2]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd3, 32'hDEADBEEF,  1};
        vec[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  1,  5'd3, 32'hDEADBEEF,  1};
        vec[4]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd3, 32'hDEADBEEF,  1};
        vec[5]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd3, 32'hDEADBEEF,  0};
        vec[6]  = '{1, 5'd5, 32'h11,       1, 5'd6, 32'h22,   0,  1,  0,  5'd3, 32'hDEADBEEF,  0};
        vec[7]  = '{1, 5'd5, 32'h11,       0, 5'd0, 32'h0,    1,  1,  0,  5'd3, 32'hDEADBEEF,  1};
        vec[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd6, 32'h22,        1};
        vec[9]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  1,  5'd6, 32'h22,        1};
        vec[10] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd6, 32'h22,        1};
        vec[11] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd5, 32'h11,        1};
        vec[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  1,  5'd5, 32'h11,        1};
        vec[13] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd5, 32'h11,        1};
        vec[14] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd5, 32'h11,        0};
        vec[15] = '{1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0,    1,  1,  0,  5'd5, 32'h11,        0};
        vec[16] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd5, 32'h11,        0};
        vec[17] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1,  1,  0,  5'd5, 32'h11,        0};

        exp_acc = '{0, 1, 2, 3, 5, 8};
`ifdef RF_WB_BYPASS_EN
        exp_hit = 1'b1;
        exp_a   = 32'hA;
        exp_b   = 32'hB;
`else
        exp_hit = 1'b0;
        exp_a   = 32'h0;
        exp_b   = 32'h0;
`endif
        for (int i = 0; i < 32; i++) regfile[i] = '0;

        // Reset state, with a load offered to check ready gating.
        idle_inputs();
        lookup_reg = 5'd3;
        reset      = 1'b1;
        mem_valid  = 1'b1;
        step();
        step();
        chk("rst_alu_ready_mv", alu_ready, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b1);
        chk("rst_we", write_enabled, 1'b0);
        chk("rst_rd", rd, 5'd0);
        chk("rst_wd", write_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hit", lookup_hit, 1'b0);
        mem_valid = 1'b0;
        #1;
        chk("rst_alu_ready", alu_ready, 1'b1);
        reset = 1'b0;

        // Per-cycle vectors: drive, compare pre-edge, then clock.
        for (int i = 0; i < NV; i++) begin
            alu_valid = vec[i].av;
            alu_rd    = vec[i].ard;
            alu_data  = vec[i].adat;
            mem_valid = vec[i].mv;
            mem_rd    = vec[i].mrd;
            mem_data  = vec[i].mdat;
            #1;
            chk($sformatf("row%0d_alu_ready", i), alu_ready, vec[i].e_ar);
            chk($sformatf("row%0d_mem_ready", i), mem_ready, vec[i].e_mr);
            chk($sformatf("row%0d_we", i), write_enabled, vec[i].e_we);
            chk($sformatf("row%0d_rd", i), rd, vec[i].e_rd);
            chk($sformatf("row%0d_wd", i), write_data, vec[i].e_wd);
            chk($sformatf("row%0d_busy", i), busy, vec[i].e_busy);
            step();
        end
        idle_inputs();

        chk("tbl_strobe_count", slog.size(), 3);
        if (slog.size() >= 3) begin
            chk("tbl_strobe0_rd", slog[0].rd, 5'd3);
            chk("tbl_strobe1_rd", slog[1].rd, 5'd6);
            chk("tbl_strobe2_rd", slog[2].rd, 5'd5);
            chk("tbl_strobe_gap", slog[2].cyc - slog[1].cyc, 3);
        end
        chk("rf_reg3", regfile[3], 32'hDEADBEEF);
        chk("rf_reg6", regfile[6], 32'h22);
        chk("rf_reg5", regfile[5], 32'h11);
        chk("rf_reg0_untouched", regfile[0], 32'h0);

        // Fill and back-pressure: six ALU writes, each held until accepted.
        s0 = slog.size();
        k  = 0;
        t  = 0;
        while (k < 6 && t < 60) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(k + 1);
            alu_data  = 32'h100 + 32'(k);
            #1;
            if (alu_ready) begin
                acc_cyc[k] = t;
                k++;
            end
            step();
            t++;
        end
        idle_inputs();
        chk("fill_accepts", k, 6);
        for (int j = 0; j < k; j++) chk($sformatf("fill_acc_cycle%0d", j), acc_cyc[j], exp_acc[j]);
        wait_idle("fill_drain");
        chk("fill_strobes", slog.size() - s0, 6);
        for (int j = 0; j < 6; j++) begin
            if (s0 + j < slog.size()) begin
                chk($sformatf("fill_rd%0d", j), slog[s0 + j].rd, 5'(j + 1));
                chk($sformatf("fill_data%0d", j), slog[s0 + j].data, 32'h100 + 32'(j));
            end
        end

        // Reset during the first strobe of three queued writes.
        for (int j = 0; j < 3; j++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(10 + j);
            alu_data  = 32'hA0 + 32'(j);
            #1;
            chk($sformatf("rstq_ready%0d", j), alu_ready, 1'b1);
            step();
        end
        idle_inputs();
        t = 0;
        while (!write_enabled && t < 20) begin
            step();
            t++;
        end
        chk("rstq_strobe_seen", write_enabled, 1'b1);
        s0    = slog.size();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstq_we", write_enabled, 1'b0);
        chk("rstq_busy", busy, 1'b0);
        chk("rstq_rd", rd, 5'd0);
        repeat (15) step();
        chk("rstq_no_more_strobes", slog.size(), s0);
        chk("rstq_reg10_committed", regfile[10], 32'hA0);
        chk("rstq_reg11_dropped", regfile[11], 32'h0);

        // Bypass: two pending writes to the same register, youngest wins.
        lookup_reg = 5'd7;
        alu_valid  = 1'b1;
        alu_rd     = 5'd7;
        alu_data   = 32'hA;
        #1;
        chk("byp_arriving_invisible", lookup_hit, 1'b0);
        step();
        alu_data = 32'hB;
        #1;
        chk("byp_first_hit", lookup_hit, exp_hit);
        chk("byp_first_data", lookup_data, exp_a);
        step();
        idle_inputs();
        #1;
        chk("byp_young_hit", lookup_hit, exp_hit);
        chk("byp_young_data", lookup_data, exp_b);
        lookup_reg = 5'd9;
        #1;
        chk("byp_other_reg_miss", lookup_hit, 1'b0);
        lookup_reg = 5'd0;
        #1;
        chk("byp_reg0_miss", lookup_hit, 1'b0);
        lookup_reg = 5'd7;
        wait_idle("byp_drain");
        chk("byp_after_commit_hit", lookup_hit, 1'b0);
        chk("byp_reg7_final", regfile[7], 32'hB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-port sequencer for the 32x32 MIPS register file. It accepts results from the ALU and load paths over valid/ready handshakes and buffers them in a small FIFO. It then drives the register file's `rd`, `write_data` and `write_enabled` inputs, one write at a time. The register file latches on the rising edge of `write_enabled`, so this block produces a clean setup, strobe and release sequence for every write.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DATA_W`, 32: result width.
- `ADDR_W`, 5: register index width.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `alu_valid` input 1: ALU result offered.
- `alu_rd` input ADDR_W: ALU destination register.
- `alu_data` input DATA_W: ALU result.
- `alu_ready` output 1: ALU result accepted this cycle if `alu_valid`.
- `mem_valid` input 1: load result offered.
- `mem_rd` input ADDR_W: load destination register.
- `mem_data` input DATA_W: load result.
- `mem_ready` output 1: load result accepted this cycle if `mem_valid`.
- `rd` output ADDR_W: register file write index.
- `write_data` output DATA_W: register file write data.
- `write_enabled` output 1: register file write strobe; the register file latches on its rising edge.
- `busy` output 1: FIFO non-empty or FSM not IDLE.
- `lookup_reg` input ADDR_W: bypass query index.
- `lookup_hit` output 1: a pending write to `lookup_reg` exists.
- `lookup_data` output DATA_W: youngest pending value for `lookup_reg`.

## Operation
- **Acceptance rule.** `mem_ready = !full` and `alu_ready = !full && !mem_valid`.
- **Arbitration.** Load has priority. At most one enqueue per cycle.
- **Register $0.** A handshake with `rd == 0` completes normally, but nothing is enqueued.
- **Ready timing.** `full` and `empty` come from the registered count. A pop in the same cycle does not raise ready.
- **Enqueue and pop in the same cycle.** Legal; the count is unchanged.
- **FIFO.** Order is preserved. Entry is {rd, data}.
- **FSM states and transitions:**
  - IDLE → SETUP when the FIFO is non-empty.
  - SETUP: drive `rd`/`write_data` from the FIFO head, `write_enabled = 0`. Go to STROBE.
  - STROBE: `write_enabled = 1`, `rd`/`write_data` held. Go to RELEASE.
  - RELEASE: `write_enabled = 0`, `rd`/`write_data` held. Pop the head at the end of this cycle. Go to SETUP if another entry remains after the pop, else IDLE.
- **Output registers.** `rd`, `write_data` and `write_enabled` are registered. They do not glitch.
- **Output values in IDLE.** `rd` and `write_data` keep their last values.
- **`busy`.** Registered-state function: `(state != IDLE) || !empty`.

## Timing
- **Reset values:**
  - `rd = 0`, `write_data = 0`, `write_enabled = 0`, `busy = 0`.
  - FIFO empty, state IDLE.
  - `alu_ready = !mem_valid`, `mem_ready = 1`.
  - `lookup_hit = 0`.
- **Latency.** A result accepted at edge N (IDLE, empty FIFO) is in SETUP after edge N+1. `write_enabled` rises at edge N+2 and falls at edge N+3.
- **Throughput.** One register write per 3 cycles under sustained load.
- **Full FIFO.** Both readies are low. Inputs must hold until accepted; no drop, no overwrite.
- **Reset mid-sequence.** All state clears at that edge and `write_enabled` is 0 in the next cycle. Queued entries are discarded. A write already strobed stays committed in the register file.

## Configuration
- **`RF_WB_BYPASS_EN` defined:**
  - `lookup_hit`/`lookup_data` are combinational over all valid FIFO entries, including the in-flight head.
  - The youngest match wins.
  - `lookup_reg == 0` never hits.
  - Entries arriving in the current cycle are not visible.
- **`RF_WB_BYPASS_EN` undefined:** the ports remain, `lookup_hit = 0` and `lookup_data = 0` constantly, and no compare logic is built.

## Structure
- **Package `rf_wb_pkg`:**
  - `ADDR_W`/`DATA_W` defaults.
  - Entry struct {rd, data}.
  - FSM state enum {IDLE, SETUP, STROBE, RELEASE}.
- **Sub-module `rf_wb_fifo`:**
  - Synchronous FIFO with push, pop, full, empty and head.
  - Exposes an entry array and a valid mask for bypass.
  - Pointers wrap modulo DEPTH; count is held in log2(DEPTH)+1 bits.
- **Top level.** Contains the arbiter, the FSM and the bypass logic.

## Test plan
- **Single write.** Reset, then ALU {rd=3, data=0xDEADBEEF} for one cycle. Expected: `alu_ready = 1`, and `write_enabled` rises exactly 2 cycles later with `rd = 3`, `write_data = 0xDEADBEEF`. `write_enabled` is high for 1 cycle and the register file reads back 0xDEADBEEF.
- **Simultaneous sources.** ALU {5, 0x11} and load {6, 0x22} valid together. Expected: `mem_ready = 1`, `alu_ready = 0`. The next cycle accepts the ALU entry. Strobes occur in order reg6 then reg5, 3 cycles apart.
- **Fill and back-pressure.** 6 back-to-back ALU writes with DEPTH=4. Expected: `alu_ready` drops after 4 accepts and returns after the first RELEASE. All 6 writes commit in order with no loss.
- **Register $0 drop.** ALU {rd=0, data=0xFFFFFFFF}. Expected: the handshake completes, there is no `write_enabled` pulse, and `busy` stays 0.
- **Reset mid-sequence.** Queue 3 writes and assert `reset` during the first STROBE. Expected: `write_enabled = 0` the next cycle, `busy = 0`, and no further strobes.
- **Bypass, with `RF_WB_BYPASS_EN`.** Queue {7, 0xA} then {7, 0xB}, with `lookup_reg = 7`. Expected: `lookup_hit = 1`, `lookup_data = 0xB`. After both commit, `lookup_hit = 0`. Without the macro, `lookup_hit` stays 0 throughout.
